// File: rtl/collision_pkg.sv
// Shared types and constants for the smiley collision detector.
package collision_pkg;

  typedef enum logic [0:0] {
    ARMED    = 1'b0,
    COOLDOWN = 1'b1
  } collision_state_t;

  localparam int COORD_W = 11;
  localparam int MAX_OBJ = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increments, holding once every bit is set.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1'b1);
    end
  end

endmodule

// File: rtl/smiley_collision_detect.sv
// Per-frame smiley/object overlap detector with a registered collision pulse.
// Optional post-report frame cooldown is enabled by SMILEY_COLLISION_COOLDOWN_EN.
module smiley_collision_detect
  import collision_pkg::*;
#(
  parameter int N_OBJ           = 4,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               smileyDrawingRequest,
  input  logic [N_OBJ-1:0]   objDrawingRequest,
  output logic               collision,
  output logic [N_OBJ-1:0]   collisionMask,
  output logic [COORD_W-1:0] hitX,
  output logic [COORD_W-1:0] hitY,
  output logic [CNT_W-1:0]   hitCount
);

  logic [N_OBJ-1:0]   ov_s;
  logic [N_OBJ-1:0]   frame_mask_r;
  logic [COORD_W-1:0] hit_x_acc_r;
  logic [COORD_W-1:0] hit_y_acc_r;
  collision_state_t   state_r;
  logic               report_s;
  logic               seed_s;
`ifdef SMILEY_COLLISION_COOLDOWN_EN
  logic [7:0]         cd_cnt_r;
`endif

  // Overlap decode, report decision, and whether the boundary overlap seeds the next frame.
  always_comb begin
    ov_s     = {N_OBJ{smileyDrawingRequest}} & objDrawingRequest;
    report_s = startOfFrame && (state_r == ARMED) && (frame_mask_r != {N_OBJ{1'b0}});
`ifdef SMILEY_COLLISION_COOLDOWN_EN
    case (state_r)
      ARMED:    seed_s = !report_s;
      COOLDOWN: seed_s = (cd_cnt_r <= 8'd1);
      default:  seed_s = 1'b0;
    endcase
`else
    seed_s = 1'b1;
`endif
  end

  // Frame accumulator, report registers and cooldown state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r       <= ARMED;
      frame_mask_r  <= {N_OBJ{1'b0}};
      hit_x_acc_r   <= {COORD_W{1'b0}};
      hit_y_acc_r   <= {COORD_W{1'b0}};
      collision     <= 1'b0;
      collisionMask <= {N_OBJ{1'b0}};
      hitX          <= {COORD_W{1'b0}};
      hitY          <= {COORD_W{1'b0}};
`ifdef SMILEY_COLLISION_COOLDOWN_EN
      cd_cnt_r      <= 8'd0;
`endif
    end else begin
      collision <= report_s;
      if (report_s) begin
        collisionMask <= frame_mask_r;
        hitX          <= hit_x_acc_r;
        hitY          <= hit_y_acc_r;
      end

      // The boundary clk opens the new frame; its overlap never counts toward the old one.
      if (startOfFrame) begin
        if (seed_s && (ov_s != {N_OBJ{1'b0}})) begin
          frame_mask_r <= ov_s;
          hit_x_acc_r  <= pixelX;
          hit_y_acc_r  <= pixelY;
        end else begin
          frame_mask_r <= {N_OBJ{1'b0}};
          hit_x_acc_r  <= {COORD_W{1'b0}};
          hit_y_acc_r  <= {COORD_W{1'b0}};
        end
      end else if (state_r == ARMED) begin
        frame_mask_r <= frame_mask_r | ov_s;
        if ((frame_mask_r == {N_OBJ{1'b0}}) && (ov_s != {N_OBJ{1'b0}})) begin
          hit_x_acc_r <= pixelX;
          hit_y_acc_r <= pixelY;
        end
      end

`ifdef SMILEY_COLLISION_COOLDOWN_EN
      if (report_s) begin
        state_r  <= COOLDOWN;
        cd_cnt_r <= 8'(COOLDOWN_FRAMES);
      end else if (startOfFrame && (state_r == COOLDOWN)) begin
        cd_cnt_r <= cd_cnt_r - 8'd1;
        if (cd_cnt_r <= 8'd1) begin
          state_r <= ARMED;
        end
      end
`else
      state_r <= ARMED;
`endif
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk    (clk),
    .resetN (resetN),
    .inc    (report_s),
    .count  (hitCount)
  );

endmodule
